// File: rtl/gavg_sequencer_pkg.sv
// Shared CNN layer-controller package: state encodings and sizing helper.
package gavg_sequencer_pkg;

    // State encodings shared with the other layer controllers
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_DIVIDE = 2'd2;
    localparam logic [1:0] ST_OUTPUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCUM  = ST_ACCUM,
        DIVIDE = ST_DIVIDE,
        OUTPUT = ST_OUTPUT
    } gavg_state_e;

    // Number of pixels in one feature map
    function automatic int gavg_pix_total(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/gavg_sequencer_if.sv
// Handshake/control bundle between the sequencer, the pixel producer,
// the averaging datapath and the downstream consumer.
// master = sequencer side, slave = producer/datapath/consumer side.
interface gavg_sequencer_if;
    logic Valid_In;
    logic Ready_In;
    logic acc_clr;
    logic acc_en;
    logic div_start;
    logic div_done;
    logic Valid_Out;
    logic Ready_Out;

    modport master (
        input  Valid_In, div_done, Ready_Out,
        output Ready_In, acc_clr, acc_en, div_start, Valid_Out
    );

    modport slave (
        output Valid_In, div_done, Ready_Out,
        input  Ready_In, acc_clr, acc_en, div_start, Valid_Out
    );
endinterface

// File: rtl/gavg_sequencer_pix_counter.sv
// Pixel counter for one frame: clear has priority; clear together with
// enable loads 1 so the first pixel of a frame is counted in the same cycle.
module gavg_pix_counter #(
    parameter int CNT_WIDTH = 12,
    parameter int TERM      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam logic [CNT_WIDTH-1:0] TERM_C = CNT_WIDTH'(TERM);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Count accepted pixels; clear restarts the frame
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= i_en ? CNT_WIDTH'(1) : '0;
        else if (i_en)
            r_cnt <= r_cnt + CNT_WIDTH'(1);
    end

    assign o_tc = (r_cnt == TERM_C);
endmodule

// File: rtl/gavg_sequencer.sv
// Global average pooling control sequencer: counts one frame of pixels into
// the datapath accumulator, kicks the divide, then holds the result until
// downstream takes it. No datapath lives here.
module gavg_sequencer
    import gavg_sequencer_pkg::*;
#(
    parameter int IMG_WIDTH   = 44,
    parameter int IMG_HEIGHT  = 44,
    parameter int CNT_WIDTH   = 12,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    gavg_sequencer_if.master       bus,
    output logic                   busy,
    output logic [FRAME_WIDTH-1:0] frame_cnt,
    output logic                   err_spurious
);
    localparam int N = gavg_pix_total(IMG_WIDTH, IMG_HEIGHT);

    gavg_state_e            r_state;
    gavg_state_e            w_next;
    logic                   r_rst_q;
    logic                   r_div_start;
    logic [FRAME_WIDTH-1:0] r_frame_cnt;
    logic                   r_err;
    logic                   w_ready_in;
    logic                   w_rdy_ok;
    logic                   w_acc_en;
    logic                   w_acc_clr;
    logic                   w_cnt_clr;
    logic                   w_cnt_en;
    logic                   w_tc;
    logic                   w_valid_out;
    logic                   w_busy;

    gavg_pix_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .TERM      (N - 1)
    ) u_pix_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    // Input is refused while reset is held and for one cycle after it
    assign w_rdy_ok = !rst && !r_rst_q;

    // Next-state and control decode; handshake outputs depend on state only
    always_comb begin
        w_next      = r_state;
        w_ready_in  = 1'b0;
        w_acc_en    = 1'b0;
        w_acc_clr   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_valid_out = 1'b0;
        w_busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                w_ready_in = w_rdy_ok;
                if (bus.Valid_In && w_rdy_ok) begin
                    w_acc_en  = 1'b1;
                    w_acc_clr = 1'b1;
                    w_cnt_clr = 1'b1;
                    if (N == 1) begin
                        w_next = DIVIDE;
                    end else begin
                        w_next   = ACCUM;
                        w_cnt_en = 1'b1;
                    end
                end
            end
            ACCUM: begin
                w_ready_in = w_rdy_ok;
                if (bus.Valid_In && w_rdy_ok) begin
                    w_acc_en = 1'b1;
                    if (w_tc) begin
                        w_next    = DIVIDE;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                if (bus.div_done)
                    w_next = OUTPUT;
            end
            OUTPUT: begin
                w_valid_out = 1'b1;
                if (bus.Ready_Out)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            w_valid_out = 1'b0;
            w_busy      = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Remember that reset was just released
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    // Divide kick: one registered pulse on entry to DIVIDE
    always_ff @(posedge clk) begin
        if (rst)
            r_div_start <= 1'b0;
        else
            r_div_start <= (w_next == DIVIDE) && (r_state != DIVIDE);
    end

    // Completed output transfers, wrapping at the counter width
    always_ff @(posedge clk) begin
        if (rst)
            r_frame_cnt <= '0;
        else if (r_state == OUTPUT && bus.Ready_Out)
            r_frame_cnt <= r_frame_cnt + FRAME_WIDTH'(1);
    end

    // Sticky flag for a divide-done pulse that arrives outside DIVIDE
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (bus.div_done && r_state != DIVIDE)
            r_err <= 1'b1;
    end

    assign bus.Ready_In  = w_ready_in;
    assign bus.acc_en    = w_acc_en;
    assign bus.acc_clr   = w_acc_clr;
    assign bus.div_start = r_div_start && !rst;
    assign bus.Valid_Out = w_valid_out;
    assign busy          = w_busy;
    assign frame_cnt     = r_frame_cnt;
    assign err_spurious  = r_err;
endmodule
